// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: peripheral address map, timer
// control bit positions and the timer register select encoding.
package mem_stage_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    typedef enum logic [1:0] {
        TSEL_TH   = 2'd0,
        TSEL_TL   = 2'd1,
        TSEL_TCON = 2'd2,
        TSEL_NONE = 2'd3
    } tsel_e;

endpackage

// File: rtl/mem_timer.sv
// Reloadable interrupt timer: TH reload value, TL up-counter, TCON control
// and status. Software writes take priority over counting and overflow.
module mem_timer
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  tsel_e       sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                // Reload always sees the TH value from before this edge
                tl_d = th_q;
                if (tcon_q[TCON_IE]) tcon_d[TCON_ST] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (we) begin
            case (sel)
                TSEL_TH:   th_d   = wdata;
                TSEL_TL:   tl_d   = wdata;
                TSEL_TCON: tcon_d = wdata[2:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            TSEL_TH:   rdata = th_q;
            TSEL_TL:   rdata = tl_q;
            TSEL_TCON: rdata = {29'd0, tcon_q};
            default:   rdata = '0;
        endcase
    end

    assign irq = tcon_q[TCON_ST] & tcon_q[TCON_IE];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data RAM plus memory-mapped timer, LED, digit tube,
// switches and cycle counter. Loads are combinational from Addr.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int RAM_AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [7:0]  Switch,
    output logic [31:0] ReadData,
    output logic [7:0]  LED,
    output logic [11:0] Digi,
    output logic        IRQ
);

    logic [31:0] addr_w;
    logic        is_ram;
    logic [RAM_AW-1:0] ram_idx;
    tsel_e       tsel;
    logic        timer_we;
    logic [31:0] timer_rdata;

    logic [31:0] ram_q [RAM_WORDS];
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;

    // Byte offset is ignored everywhere; all decode works on the word address
    assign addr_w  = Addr & 32'hFFFF_FFFC;
    assign is_ram  = (addr_w[31:RAM_AW+2] == '0);
    assign ram_idx = addr_w[RAM_AW+1:2];

    always_comb begin
        tsel = TSEL_NONE;
        case (addr_w)
            ADDR_TH:   tsel = TSEL_TH;
            ADDR_TL:   tsel = TSEL_TL;
            ADDR_TCON: tsel = TSEL_TCON;
            default:   tsel = TSEL_NONE;
        endcase
    end

    assign timer_we = MemWrite && (tsel != TSEL_NONE);

    mem_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .we    (timer_we),
        .sel   (tsel),
        .wdata (WriteData),
        .rdata (timer_rdata),
        .irq   (IRQ)
    );

    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) ram_q[ram_idx] <= WriteData;
    end

    always_comb begin
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;
        if (MemWrite && addr_w == ADDR_LED)  led_d  = WriteData[7:0];
        if (MemWrite && addr_w == ADDR_DIGI) digi_d = WriteData[11:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (is_ram) begin
                ReadData = ram_q[ram_idx];
            end else begin
                case (addr_w)
                    ADDR_TH, ADDR_TL, ADDR_TCON: ReadData = timer_rdata;
                    ADDR_LED:     ReadData = {24'd0, led_q};
                    ADDR_SWITCH:  ReadData = {24'd0, Switch};
                    ADDR_DIGI:    ReadData = {20'd0, digi_q};
                    ADDR_SYSTICK: ReadData = systick_q;
                    default:      ReadData = '0;
                endcase
            end
        end
    end

    assign LED  = led_q;
    assign Digi = digi_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, RAM, timer reload/IRQ, write
// collisions, peripherals and read-before-write behaviour.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [7:0]  Switch;
    logic [31:0] ReadData;
    logic [7:0]  LED;
    logic [11:0] Digi;
    logic        IRQ;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.RAM_WORDS(256), .RAM_AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .Switch    (Switch),
        .ReadData  (ReadData),
        .LED       (LED),
        .Digi      (Digi),
        .IRQ       (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        Addr      = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Addr     = a;
        #1;
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Addr = '0; WriteData = '0; Switch = 8'h00;
        repeat (2) tick();
        check("rst_led",  {24'd0, LED}, 32'h0);
        check("rst_digi", {20'd0, Digi}, 32'h0);
        check("rst_irq",  {31'd0, IRQ}, 32'h0);
        reset = 1'b0;
        rd(32'h4000_0018);
        check("systick0", ReadData, 32'h0);
        tick();
        check("systick1", ReadData, 32'h1);
        MemRead = 1'b0; #1;
        check("rd_idle_zero", ReadData, 32'h0);

        // RAM store / load
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010);
        check("ram_rd",      ReadData, 32'hDEAD_BEEF);
        rd(32'h0000_0013);
        check("ram_rd_byte", ReadData, 32'hDEAD_BEEF);
        rd(32'h0000_0400);
        check("ram_oob",     ReadData, 32'h0);

        // Timer reload and IRQ
        wr(32'h4000_0000, 32'hFFFF_FFFD);
        wr(32'h4000_0004, 32'hFFFF_FFFD);
        wr(32'h4000_0008, 32'h0000_0003);
        rd(32'h4000_0008);
        check("tcon_rd", ReadData, 32'h3);
        rd(32'h4000_0004);
        check("tl_start", ReadData, 32'hFFFF_FFFD);
        tick();
        check("tl_fe", ReadData, 32'hFFFF_FFFE);
        tick();
        check("tl_ff", ReadData, 32'hFFFF_FFFF);
        check("irq_pre", {31'd0, IRQ}, 32'h0);
        tick();
        check("tl_reload",  ReadData, 32'hFFFF_FFFD);
        check("irq_reload", {31'd0, IRQ}, 32'h1);
        rd(32'h4000_0008);
        check("tcon_status", ReadData, 32'h7);
        wr(32'h4000_0008, 32'h0000_0003);
        check("irq_clear", {31'd0, IRQ}, 32'h0);

        // Overflow colliding with a TCON write: status set is lost
        wr(32'h4000_0008, 32'h0000_0000);
        wr(32'h4000_0004, 32'hFFFF_FFFE);
        wr(32'h4000_0008, 32'h0000_0003);
        rd(32'h4000_0004);
        check("col_tl_fe", ReadData, 32'hFFFF_FFFE);
        tick();
        check("col_tl_ff", ReadData, 32'hFFFF_FFFF);
        wr(32'h4000_0008, 32'h0000_0003);
        check("col_irq", {31'd0, IRQ}, 32'h0);
        rd(32'h4000_0004);
        check("col_reload", ReadData, 32'hFFFF_FFFD);

        // TL write beats increment
        wr(32'h4000_0004, 32'h0000_0005);
        rd(32'h4000_0004);
        check("tl_5", ReadData, 32'h5);
        wr(32'h4000_0004, 32'h0000_0100);
        rd(32'h4000_0004);
        check("tl_wr_win", ReadData, 32'h100);
        tick();
        check("tl_101", ReadData, 32'h101);

        // Peripherals
        wr(32'h4000_000C, 32'h0000_01A5);
        check("led", {24'd0, LED}, 32'hA5);
        rd(32'h4000_000C);
        check("led_rd", ReadData, 32'hA5);
        wr(32'h4000_0014, 32'h000F_FF7F);
        check("digi", {20'd0, Digi}, 32'hF7F);
        Switch = 8'h3C;
        rd(32'h4000_0010);
        check("switch", ReadData, 32'h3C);
        wr(32'h4000_0010, 32'hFFFF_FFFF);
        rd(32'h4000_0010);
        check("switch_ro", ReadData, 32'h3C);
        check("led_kept", {24'd0, LED}, 32'hA5);
        rd(32'h4000_0020);
        check("unmapped", ReadData, 32'h0);

        // Read and write in the same cycle
        wr(32'h0000_0000, 32'h0000_0001);
        MemRead = 1'b1; MemWrite = 1'b1; Addr = 32'h0; WriteData = 32'h2;
        #1;
        check("rw_old", ReadData, 32'h1);
        tick();
        MemWrite = 1'b0;
        #1;
        check("rw_new", ReadData, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Takes the ALU result as the address and the forwarded store data (DatabusB_DM), and performs data-RAM or memory-mapped peripheral accesses.
- Returns read data to the MEM/WB path.
- Contains the data RAM, a reloadable interrupt timer, LED/digit-tube output registers, a switch input and a free-running cycle counter. It raises IRQ toward the control unit.

Parameters:
RAM_WORDS, 256, depth of data RAM in 32-bit words (power of two)
RAM_AW, 8, word-address width = log2(RAM_WORDS)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MemRead  input  1  load in MEM this cycle
MemWrite  input  1  store in MEM this cycle
Addr  input  32  byte address (EX ALU_out, registered by EX/MEM)
WriteData  input  32  store data (EX DatabusB_DM, registered by EX/MEM)
Switch  input  8  board switches, sampled raw
ReadData  output  32  load result, combinational from Addr
LED  output  8  LED register
Digi  output  12  digit-tube register (anodes[11:8], segments[7:0])
IRQ  output  1  timer interrupt request

Behaviour:
- One clock (clk). Reset is synchronous and active-high: all state updates on posedge clk; reset=1 at an edge overrides every other action.
- Reset values:
  - TH=0, TL=0, TCON=0, LED=0, Digi=0, SysTick=0.
  - IRQ=0.
  - Data RAM is not reset and is uninitialised in simulation.
- Address map (Addr[1:0] ignored; word accesses only):
  - 0x00000000..(4*RAM_WORDS-1): data RAM, index Addr[RAM_AW+1:2].
  - 0x40000000 TH: rw, 32-bit.
  - 0x40000004 TL: rw, 32-bit.
  - 0x40000008 TCON: rw, [2:0]; reads zero-extended.
  - 0x4000000C LED: rw, [7:0].
  - 0x40000010 Switch: ro; reads {24'b0, Switch}.
  - 0x40000014 Digi: rw, [11:0].
  - 0x40000018 SysTick: ro, 32-bit.
  - Anything else: reads 0, writes ignored.
- Read path:
  - ReadData is combinational.
  - ReadData = 0 when MemRead=0.
  - Zero-cycle latency, so a load result is valid in the same cycle as Addr.
  - A read in the same cycle as a write to the same location returns the old value.
- Write path:
  - When MemWrite=1, the target updates at the edge.
  - A write to a read-only address is a no-op.
  - MemRead and MemWrite both high: write happens, and ReadData shows the pre-write value.
- SysTick: increments by 1 every cycle and wraps 0xFFFFFFFF->0.
- Timer, TCON bits: [0] enable, [1] interrupt enable, [2] interrupt status.
  - When TCON[0]=1, each cycle:
    - If TL==0xFFFFFFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
    - Otherwise TL<=TL+1.
  - When TCON[0]=0: TL holds.
  - Software write to TL in the same cycle as an increment or reload: the write wins.
  - Software write to TCON: all three bits take WriteData[2:0]. Software clears status by writing bit2=0.
  - Write to TCON in the same cycle as an overflow: the write wins; the overflow status set is lost.
  - Write to TH takes effect for the next reload. A TH write in the same cycle as a reload means the reload uses the old TH.
- IRQ = TCON[2] & TCON[1], combinational from registers.

Decomposition:
- Shared package holds:
  - Address constants: ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_SWITCH, ADDR_DIGI, ADDR_SYSTICK, PERIPH_BASE=0x40000000.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_ST=2.
- One sub-module, mem_timer, holds TH/TL/TCON and IRQ, with a write-enable/select/data input and read-data output.
- RAM, decode, LED/Digi/SysTick and the read mux stay in mem_stage.

Test Plan:
- Reset then idle: assert reset 2 cycles -> LED=0, Digi=0, IRQ=0. With MemRead=1 at 0x40000018 one cycle after reset release, ReadData=1.
- RAM store/load: write 0xDEADBEEF to 0x00000010, next cycle read 0x00000010 -> 0xDEADBEEF. Read 0x00000013 -> same. Read 0x00000400 -> 0.
- Timer reload and IRQ:
  - Setup: TH=0xFFFFFFFD, TL=0xFFFFFFFD, TCON=3.
  - Required: TL reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0xFFFFFFFD; IRQ=1 from the reload edge.
  - Then write TCON=3: IRQ=0 next cycle.
- Collision:
  - Enabled timer with TL=0xFFFFFFFF; in the same cycle write TCON=0x3 -> IRQ stays 0.
  - TL=5 counting with a TL write of 0x100 -> TL=0x100 next cycle, 0x101 after.
- Peripherals:
  - Write LED=0x1A5 -> LED=0xA5.
  - Write Digi=0xFFF7F -> Digi=0xF7F.
  - Switch=0x3C -> read 0x40000010 gives 0x0000003C.
  - Write to 0x40000010 -> no effect.
- Read/write same cycle: RAM[0]=1; MemRead=MemWrite=1 at 0 with WriteData 2 -> ReadData=1 this cycle, 2 next cycle.
